// File: rtl/fp_normalize_pipe_pkg.sv
// Shared widths, constants and stage payload for the FP normalise pipe.
// Payload widths follow the package default configuration.
package fp_norm_pkg;

  localparam int FPN_EXP_W  = 8;
  localparam int FPN_FRAC_W = 23;
  localparam int FPN_GRS_W  = 4;

  function automatic int mant_w(
    input int frac_w,
    input int grs_w
  );
    return frac_w + grs_w + 2;
  endfunction

  function automatic int lz_w(input int m_w);
    return $clog2(m_w);
  endfunction

  localparam int FPN_MANT_W = mant_w(FPN_FRAC_W, FPN_GRS_W);
  localparam int FPN_LZ_W   = lz_w(FPN_MANT_W);
  localparam int FPN_XEXP_W = FPN_EXP_W + 2;

  localparam logic [FPN_EXP_W-1:0] EXP_ALL_ONES = '1;

  typedef struct packed {
    logic                  sign;
    logic                  zero;
    logic [FPN_LZ_W-1:0]   lz;
    logic [FPN_XEXP_W-1:0] exp;
    logic [FPN_MANT_W-1:0] mant;
  } norm_stage_t;

endpackage

// File: rtl/fp_normalize_pipe_if.sv
// Valid/ready bus for fp_normalize_pipe: input beat and packed result.
interface fp_normalize_pipe_if #(
  parameter int EXP_W  = fp_norm_pkg::FPN_EXP_W,
  parameter int FRAC_W = fp_norm_pkg::FPN_FRAC_W,
  parameter int GRS_W  = fp_norm_pkg::FPN_GRS_W
);
  localparam int MANT_W = fp_norm_pkg::mant_w(FRAC_W, GRS_W);

  logic                    in_valid;
  logic                    in_ready;
  logic [MANT_W-1:0]       mantissa_in;
  logic [EXP_W-1:0]        exp_in;
  logic                    sign_in;
  logic                    out_valid;
  logic                    out_ready;
  logic [EXP_W+FRAC_W:0]   out_data;
  logic                    out_ovf;
  logic                    out_unf;
  logic                    out_inexact;

  modport master (
    output in_valid, mantissa_in, exp_in, sign_in,
    output out_ready,
    input  in_ready, out_valid, out_data,
    input  out_ovf, out_unf, out_inexact
  );

  modport slave (
    input  in_valid, mantissa_in, exp_in, sign_in,
    input  out_ready,
    output in_ready, out_valid, out_data,
    output out_ovf, out_unf, out_inexact
  );

endinterface

// File: rtl/fp_normalize_pipe_lzc.sv
// fp_lzc: combinational leading-zero counter with all-zero flag.
module fp_lzc #(
  parameter int W  = 28,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  d,
  output logic [CW-1:0] count,
  output logic          all_zero
);

  always_comb begin
    count    = '0;
    all_zero = 1'b1;
    for (int i = W - 1; i >= 0; i--) begin
      if (all_zero) begin
        if (d[i]) all_zero = 1'b0;
        else      count    = count + CW'(1);
      end
    end
  end

endmodule

// File: rtl/fp_normalize_pipe.sv
// Three-stage normalise/round/pack with valid/ready backpressure.
// Define FP_NORM_RNE_EN for round-to-nearest-even, else truncate.
module fp_normalize_pipe
  import fp_norm_pkg::*;
#(
  parameter int EXP_W  = FPN_EXP_W,
  parameter int FRAC_W = FPN_FRAC_W,
  parameter int GRS_W  = FPN_GRS_W
) (
  input logic          clk,
  input logic          rst_n,
  fp_normalize_pipe_if.slave bus
);

  localparam int MANT_W = mant_w(FRAC_W, GRS_W);
  localparam int LZ_W   = lz_w(MANT_W);
  localparam int XW     = EXP_W + 2;
  localparam int DW     = 1 + EXP_W + FRAC_W;

  localparam logic signed [XW-1:0] EXP_MAX =
    {2'b00, {EXP_W{1'b1}}};
  localparam logic signed [XW-1:0] EXP_ZERO = '0;

  logic        s1_valid, s2_valid, s3_valid;
  norm_stage_t s1_q, s2_q, s1_d, s2_d;

  logic s3_free, s2_adv, s2_free;
  logic s1_adv, s1_free;

  assign s3_free = !s3_valid || bus.out_ready;
  assign s2_adv  = s2_valid && s3_free;
  assign s2_free = !s2_valid || s2_adv;
  assign s1_adv  = s1_valid && s2_free;
  assign s1_free = !s1_valid || s1_adv;

  assign bus.in_ready = s1_free;

  logic [LZ_W-1:0] lz_in;
  logic            lz_zero;

  fp_lzc #(
    .W  (MANT_W - 1),
    .CW (LZ_W)
  ) u_lzc (
    .d        (bus.mantissa_in[MANT_W-2:0]),
    .count    (lz_in),
    .all_zero (lz_zero)
  );

  always_comb begin
    s1_d      = '0;
    s1_d.sign = bus.sign_in;
    s1_d.zero = lz_zero && !bus.mantissa_in[MANT_W-1];
    s1_d.lz   = lz_in;
    s1_d.exp  = {2'b00, bus.exp_in};
    s1_d.mant = bus.mantissa_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else begin
      if (s1_free) s1_valid <= bus.in_valid;
      if (s1_free && bus.in_valid) s1_q <= s1_d;
    end
  end

  // overflow bit: shift right, folding the lost bit into sticky
  always_comb begin
    s2_d = s1_q;
    if (s1_q.zero) begin
      s2_d.mant = '0;
      s2_d.exp  = '0;
    end else if (s1_q.mant[MANT_W-1]) begin
      s2_d.mant = {1'b0, s1_q.mant[MANT_W-1:2],
                   |s1_q.mant[1:0]};
      s2_d.exp  = s1_q.exp + XW'(1);
    end else begin
      s2_d.mant = s1_q.mant << s1_q.lz;
      s2_d.exp  = s1_q.exp - XW'(s1_q.lz);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_q     <= '0;
    end else begin
      if (s2_free) s2_valid <= s1_valid;
      if (s1_adv) s2_q <= s2_d;
    end
  end

  logic                   hid, guard, sticky, inc;
  logic [FRAC_W-1:0]      frac, frac_r;
  logic [GRS_W-1:0]       grs;
  logic [FRAC_W+1:0]      sig_r;
  logic signed [XW-1:0]   exp_r;
  logic [DW-1:0]          d_data;
  logic                   d_ovf, d_unf, d_inx;

  always_comb begin
    hid    = s2_q.mant[MANT_W-2];
    frac   = s2_q.mant[MANT_W-3 -: FRAC_W];
    grs    = s2_q.mant[GRS_W-1:0];
    guard  = grs[GRS_W-1];
    sticky = |grs[GRS_W-2:0];
`ifdef FP_NORM_RNE_EN
    inc    = guard && (sticky || frac[0]);
`else
    inc    = 1'b0;
`endif
    sig_r  = {1'b0, hid, frac}
           + {{(FRAC_W+1){1'b0}}, inc};
    exp_r  = $signed(s2_q.exp);
    frac_r = sig_r[FRAC_W-1:0];
    if (sig_r[FRAC_W+1]) begin
      exp_r  = exp_r + XW'(1);
      frac_r = '0;
    end
    d_data = '0;
    d_ovf  = 1'b0;
    d_unf  = 1'b0;
    d_inx  = 1'b0;
    if (s2_q.zero) begin
      d_data = {s2_q.sign, {(DW-1){1'b0}}};
    end else begin
      d_inx = guard || sticky;
      if (exp_r <= EXP_ZERO) begin
        d_unf  = 1'b1;
        d_data = {s2_q.sign, {(DW-1){1'b0}}};
      end else if (exp_r >= EXP_MAX) begin
        d_ovf  = 1'b1;
        d_data = {s2_q.sign, {EXP_W{1'b1}},
                  {FRAC_W{1'b0}}};
      end else begin
        d_data = {s2_q.sign, exp_r[EXP_W-1:0], frac_r};
      end
    end
  end

  logic          unused_bits;
  assign unused_bits = ^{s2_q.lz, s2_q.mant[MANT_W-1],
                         sig_r[FRAC_W]};

  logic [DW-1:0] out_q;
  logic          ovf_q, unf_q, inx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s3_valid <= 1'b0;
      out_q    <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      inx_q    <= 1'b0;
    end else begin
      if (s3_free) s3_valid <= s2_valid;
      if (s2_adv) begin
        out_q <= d_data;
        ovf_q <= d_ovf;
        unf_q <= d_unf;
        inx_q <= d_inx;
      end
    end
  end

  assign bus.out_valid   = s3_valid;
  assign bus.out_data    = out_q;
  assign bus.out_ovf     = ovf_q;
  assign bus.out_unf     = unf_q;
  assign bus.out_inexact = inx_q;

endmodule

// File: tb/tb_fp_normalize_pipe.sv
// Directed bench for fp_normalize_pipe (both rounding builds).
// Expectations hand-derived from IEEE single-precision packing.
module tb_fp_normalize_pipe;
  import fp_norm_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  fp_normalize_pipe_if bif ();

  fp_normalize_pipe dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

`ifdef FP_NORM_RNE_EN
  localparam logic [31:0] TIE_X   = 32'h3F80_0002;
  localparam logic [31:0] CARRY_X = 32'h4000_0000;
`else
  localparam logic [31:0] TIE_X   = 32'h3F80_0001;
  localparam logic [31:0] CARRY_X = 32'h3FFF_FFFF;
`endif

  localparam logic [31:0] OVF_X =
    {1'b0, EXP_ALL_ONES, 23'h0};

  task automatic chk(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [28:0] bp_mant(input int i);
    return 29'h0800_0000 | 29'(i << 4);
  endfunction

  function automatic logic [31:0] bp_exp(input int i);
    return {1'b0, 8'h70 + 8'(i), 23'(i)};
  endfunction

  task automatic drive(
    input logic [28:0] m,
    input logic [7:0]  e,
    input logic        s
  );
    bif.in_valid    = 1'b1;
    bif.mantissa_in = m;
    bif.exp_in      = e;
    bif.sign_in     = s;
  endtask

  task automatic run_vec(
    input string       tag,
    input logic [28:0] m,
    input logic [7:0]  e,
    input logic        s,
    input logic [31:0] xd,
    input logic        xo,
    input logic        xu,
    input logic        xi
  );
    int lat;
    @(negedge clk);
    bif.out_ready = 1'b1;
    drive(m, e, s);
    #1;
    chk({tag, "_rdy"}, 64'(bif.in_ready), 64'd1);
    @(negedge clk);
    bif.in_valid = 1'b0;
    lat = 1;
    while (!bif.out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_lat"}, 64'(lat), 64'd3);
    chk({tag, "_data"}, 64'(bif.out_data), 64'(xd));
    chk({tag, "_ovf"}, 64'(bif.out_ovf), 64'(xo));
    chk({tag, "_unf"}, 64'(bif.out_unf), 64'(xu));
    chk({tag, "_inx"}, 64'(bif.out_inexact), 64'(xi));
  endtask

  initial begin
    int  sent;
    int  got;
    logic acc;

    bif.in_valid    = 1'b0;
    bif.mantissa_in = '0;
    bif.exp_in      = '0;
    bif.sign_in     = 1'b0;
    bif.out_ready   = 1'b0;

    #1 rst_n = 1'b0;
    #1;
    chk("rst_valid", 64'(bif.out_valid), 64'd0);
    chk("rst_data", 64'(bif.out_data), 64'd0);
    chk("rst_ovf", 64'(bif.out_ovf), 64'd0);
    chk("rst_unf", 64'(bif.out_unf), 64'd0);
    chk("rst_inx", 64'(bif.out_inexact), 64'd0);
    chk("rst_rdy", 64'(bif.in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;

    run_vec("right", 29'h1000_0000, 8'h80, 1'b0,
            32'h4080_0000, 0, 0, 0);
    run_vec("left", 29'h0200_0000, 8'h80, 1'b0,
            32'h3F00_0000, 0, 0, 0);
    run_vec("zero", 29'h0, 8'h45, 1'b1,
            32'h8000_0000, 0, 0, 0);
    run_vec("tie", 29'h0800_0018, 8'h7F, 1'b0,
            TIE_X, 0, 0, 1);
    run_vec("ovf", 29'h1000_0000, 8'hFE, 1'b0,
            OVF_X, 1, 0, 0);
    run_vec("unf", 29'h0000_0010, 8'h05, 1'b0,
            32'h0000_0000, 0, 1, 0);
    run_vec("carry", 29'h0FFF_FFF8, 8'h7F, 1'b0,
            CARRY_X, 0, 0, 1);
    run_vec("exp_ff", 29'h0800_0000, 8'hFF, 1'b1,
            32'hFF80_0000, 1, 0, 0);
    run_vec("sticky", 29'h0800_0001, 8'h7F, 1'b1,
            32'hBF80_0000, 0, 0, 1);
    run_vec("rsticky", 29'h1000_0001, 8'h80, 1'b0,
            32'h4080_0000, 0, 0, 1);
    run_vec("exp0", 29'h0800_0000, 8'h00, 1'b0,
            32'h0000_0000, 0, 1, 0);
    run_vec("exp1", 29'h0800_0000, 8'h01, 1'b0,
            32'h0080_0000, 0, 0, 0);

    // backpressure: fill with out_ready low
    @(negedge clk);
    bif.out_ready = 1'b0;
    @(negedge clk);
    sent = 0;
    for (int c = 0; c < 10 && sent < 5; c++) begin
      drive(bp_mant(sent), 8'h70 + 8'(sent), 1'b0);
      #1;
      acc = bif.in_ready;
      @(negedge clk);
      if (acc) sent++;
      else break;
    end
    chk("bp_accepts", 64'(sent), 64'd3);
    chk("bp_rdy_low", 64'(bif.in_ready), 64'd0);
    chk("bp_valid", 64'(bif.out_valid), 64'd1);
    chk("bp_hold0", 64'(bif.out_data), 64'(bp_exp(0)));
    repeat (3) @(negedge clk);
    chk("bp_hold1", 64'(bif.out_data), 64'(bp_exp(0)));
    chk("bp_rdy_still", 64'(bif.in_ready), 64'd0);

    bif.out_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 40 && got < 5; c++) begin
      if (bif.out_valid) begin
        chk("bp_order", 64'(bif.out_data),
            64'(bp_exp(got)));
        got++;
      end
      if (sent < 5) begin
        drive(bp_mant(sent), 8'h70 + 8'(sent), 1'b0);
        #1;
        acc = bif.in_ready;
      end else begin
        bif.in_valid = 1'b0;
        acc = 1'b0;
      end
      @(negedge clk);
      if (acc) sent++;
    end
    bif.in_valid = 1'b0;
    chk("bp_got", 64'(got), 64'd5);
    chk("bp_sent", 64'(sent), 64'd5);
    repeat (2) @(negedge clk);
    chk("bp_no_dup", 64'(bif.out_valid), 64'd0);

    // reset with beats in flight
    for (int i = 0; i < 3; i++) begin
      drive(bp_mant(i), 8'h70 + 8'(i), 1'b0);
      @(negedge clk);
    end
    bif.in_valid = 1'b0;
    chk("mid_valid", 64'(bif.out_valid), 64'd1);
    chk("mid_data", 64'(bif.out_data), 64'(bp_exp(0)));
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(bif.out_valid), 64'd0);
    chk("arst_data", 64'(bif.out_data), 64'd0);
    chk("arst_rdy", 64'(bif.in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("arst_drop", 64'(bif.out_valid), 64'd0);
    run_vec("post_rst", 29'h0200_0000, 8'h80, 1'b1,
            32'hBF00_0000, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
